uart_mem_loader: RTL and testbench

- Byte-stream-to-memory loader that sits directly upstream of the 1024x32 single-port on-chip program/data RAM.
- Packs incoming bytes (e.g. from the UART receiver) little-endian into 32-bit words and writes them through the RAM's slave port (address, byteenable, chipselect, write, writedata, clken).
- Used to download program/data images at runtime. Also reports a running byte checksum and an address-wrap error.

---
 rtl/uart_mem_loader_if.sv | 36 +++
 rtl/uart_mem_loader.sv | 153 +++++++++++++++
 tb/tb_uart_mem_loader.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_loader_if
// Purpose  : Byte-stream handshake plus RAM slave-port bundle for the
//            uart_mem_loader. The master modport is the loader's view; the
//            slave modport is the stream source / RAM side.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_mem_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic              mem_clken;

    modport master (
        input  in_data, in_valid,
        output in_ready,
        output mem_address, mem_byteenable, mem_chipselect,
        output mem_write, mem_writedata, mem_clken
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready,
        input  mem_address, mem_byteenable, mem_chipselect,
        input  mem_write, mem_writedata, mem_clken
    );
endinterface
`default_nettype wire

// File: rtl/uart_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_loader
// Purpose  : Packs an incoming byte stream little-endian into 32-bit words and
//            writes them into a single-port RAM. Keeps a 16-bit byte checksum
//            and a sticky flag for loads that run past the top of the RAM.
// Revision : 1.0 - initial release
// ============================================================================
module uart_mem_loader #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  byte_count,
    uart_mem_loader_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              wrap_err,
    output logic [15:0]       checksum
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_remaining;
    logic [1:0]        r_lane;
    logic [3:0]        r_be;
    logic [31:0]       r_word;
    logic [15:0]       r_checksum;
    logic              r_wrap;

    logic              w_in_ready;
    logic              w_write;
    logic              w_accept;
    logic              w_last_byte;
    logic [31:0]       w_lane_mask;

    assign w_accept    = w_in_ready & bus.in_valid;
    assign w_last_byte = (r_lane == 2'd3) || (r_remaining == CNT_W'(1));

    // State register; reset aborts any load in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_write    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (byte_count != '0) ? S_COLLECT : S_DONE;
                end
            end
            S_COLLECT: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && w_last_byte) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_write = 1'b1;
                w_next  = (r_remaining != '0) ? S_COLLECT : S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: address, byte counter, lane packing, checksum, wrap flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_lane      <= 2'd0;
            r_be        <= 4'd0;
            r_word      <= 32'd0;
            r_checksum  <= 16'd0;
            r_wrap      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= base_addr;
                        r_remaining <= byte_count;
                        r_checksum  <= 16'd0;
                        r_wrap      <= 1'b0;
                        r_lane      <= 2'd0;
                        r_be        <= 4'd0;
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        r_word[{r_lane, 3'b000} +: 8] <= bus.in_data;
                        r_be[r_lane]                  <= 1'b1;
                        r_checksum  <= r_checksum + 16'(bus.in_data);
                        r_remaining <= r_remaining - CNT_W'(1);
                        r_lane      <= r_lane + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_addr <= r_addr + ADDR_W'(1);
                    // Crossing the top only counts if more bytes still follow
                    if ((&r_addr) && (r_remaining != '0)) begin
                        r_wrap <= 1'b1;
                    end
                    r_lane <= 2'd0;
                    r_be   <= 4'd0;
                end
                default: begin
                end
            endcase
        end
    end

    // Stale bytes from an earlier word may sit in unused lanes; force them to 0
    assign w_lane_mask = {{8{r_be[3]}}, {8{r_be[2]}}, {8{r_be[1]}}, {8{r_be[0]}}};

    assign bus.in_ready       = w_in_ready;
    assign bus.mem_address    = r_addr;
    assign bus.mem_chipselect = w_write;
    assign bus.mem_write      = w_write;
    assign bus.mem_byteenable = w_write ? r_be : 4'd0;
    assign bus.mem_writedata  = w_write ? (r_word & w_lane_mask) : 32'd0;
    assign bus.mem_clken      = 1'b1;

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign wrap_err = r_wrap;
    assign checksum = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_mem_loader
// Purpose  : Directed self-checking bench for uart_mem_loader with a
//            byte-enabled RAM model attached to the loader's write port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mem_loader;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  byte_count;
    logic              busy;
    logic              done;
    logic              wrap_err;
    logic [15:0]       checksum;

    uart_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    uart_mem_loader #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .byte_count (byte_count),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .wrap_err   (wrap_err),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // RAM model and write log, both owned by the negedge process
    logic [31:0] ram [0:1023] = '{default: '0};
    int          wr_cnt = 0;
    logic [9:0]  wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    logic [3:0]  wr_be   [0:63];
    logic        seed_en   = 1'b0;
    logic [9:0]  seed_addr = '0;
    logic [31:0] seed_data = '0;

    always @(negedge clk) begin
        if (seed_en) ram[seed_addr] <= seed_data;
        if (bus.mem_clken && bus.mem_chipselect && bus.mem_write) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_byteenable[b])
                    ram[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
            wr_addr[wr_cnt[5:0]] <= bus.mem_address;
            wr_data[wr_cnt[5:0]] <= bus.mem_writedata;
            wr_be[wr_cnt[5:0]]   <= bus.mem_byteenable;
            wr_cnt <= wr_cnt + 1;
        end
    end

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] stim [0:7];
    int         w0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] n);
        base_addr  = a;
        byte_count = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Offers stim[0..n-1]; returns just after the edge that accepted the last byte
    task automatic send_stream(input int n, input bit throttle, input bit stray);
        int idx = 0;
        int cyc = 0;
        bit phase = 1'b1;
        bit stray_done = 1'b0;
        bit acc;
        while (idx < n && cyc < 200) begin
            bus.in_data  = stim[idx];
            bus.in_valid = throttle ? phase : 1'b1;
            if (stray && !stray_done && idx == 2) begin
                start      = 1'b1;
                base_addr  = 10'h100;
                byte_count = 12'd4;
                stray_done = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) idx++;
            phase = ~phase;
            cyc++;
        end
        bus.in_valid = 1'b0;
        start        = 1'b0;
        check_val("stream_bytes_taken", 32'(idx), 32'(n));
    endtask

    task automatic wait_done();
        for (int k = 0; k < 50 && !done; k++) tick();
        check_val("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; byte_count = '0;
        bus.in_data = 8'h00; bus.in_valid = 1'b0;
        tick(); tick();

        // Reset state
        check_val("rst_busy",     32'(busy), 32'd0);
        check_val("rst_done",     32'(done), 32'd0);
        check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_val("rst_clken",    32'(bus.mem_clken), 32'd1);
        check_val("rst_addr",     32'(bus.mem_address), 32'd0);
        check_val("rst_write",    32'(bus.mem_write), 32'd0);
        check_val("rst_checksum", 32'(checksum), 32'd0);
        check_val("rst_wrap",     32'(wrap_err), 32'd0);
        reset = 1'b0;
        tick();

        // Full words, back-to-back
        stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        w0 = wr_cnt;
        do_start(10'h010, 12'd8);
        check_val("full_busy", 32'(busy), 32'd1);
        send_stream(8, 1'b0, 1'b0);
        check_val("full_lat_write", 32'(bus.mem_write), 32'd1);
        check_val("full_lat_data",  bus.mem_writedata, 32'h88776655);
        tick();
        check_val("full_done",     32'(done), 32'd1);
        check_val("full_checksum", 32'(checksum), 32'h0264);
        check_val("full_wrap",     32'(wrap_err), 32'd0);
        tick();
        check_val("full_done_pulse", 32'(done), 32'd0);
        check_val("full_idle",       32'(busy), 32'd0);
        check_val("full_nwr",  32'(wr_cnt - w0), 32'd2);
        check_val("full_a0",   32'(wr_addr[w0]),   32'h010);
        check_val("full_d0",   wr_data[w0],        32'h44332211);
        check_val("full_be0",  32'(wr_be[w0]),     32'hF);
        check_val("full_a1",   32'(wr_addr[w0+1]), 32'h011);
        check_val("full_be1",  32'(wr_be[w0+1]),   32'hF);
        check_val("full_ram0", ram[10'h010], 32'h44332211);
        check_val("full_ram1", ram[10'h011], 32'h88776655);

        // Partial tail over a pre-seeded word
        seed_addr = 10'h021; seed_data = 32'h12345678; seed_en = 1'b1;
        @(negedge clk); #1 seed_en = 1'b0;
        tick();
        stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h00};
        w0 = wr_cnt;
        do_start(10'h020, 12'd6);
        send_stream(6, 1'b0, 1'b0);
        wait_done();
        check_val("part_checksum", 32'(checksum), 32'h04FB);
        tick();
        check_val("part_nwr",  32'(wr_cnt - w0), 32'd2);
        check_val("part_d0",   wr_data[w0],      32'hDDCCBBAA);
        check_val("part_a1",   32'(wr_addr[w0+1]), 32'h021);
        check_val("part_d1",   wr_data[w0+1],    32'h0000FFEE);
        check_val("part_be1",  32'(wr_be[w0+1]), 32'h3);
        check_val("part_ram0", ram[10'h020], 32'hDDCCBBAA);
        check_val("part_ram1", ram[10'h021], 32'h1234FFEE);

        // Zero length
        w0 = wr_cnt;
        do_start(10'h050, 12'd0);
        check_val("zero_done",     32'(done), 32'd1);
        check_val("zero_in_ready", 32'(bus.in_ready), 32'd0);
        check_val("zero_checksum", 32'(checksum), 32'd0);
        tick();
        check_val("zero_done_pulse", 32'(done), 32'd0);
        check_val("zero_nwr", 32'(wr_cnt - w0), 32'd0);

        // Wrap past the top of RAM
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        w0 = wr_cnt;
        do_start(10'h3FF, 12'd8);
        send_stream(8, 1'b0, 1'b0);
        wait_done();
        check_val("wrap_flag",     32'(wrap_err), 32'd1);
        check_val("wrap_checksum", 32'(checksum), 32'h0024);
        tick();
        check_val("wrap_hold", 32'(wrap_err), 32'd1);
        check_val("wrap_a0",   32'(wr_addr[w0]),   32'h3FF);
        check_val("wrap_d0",   wr_data[w0],        32'h04030201);
        check_val("wrap_a1",   32'(wr_addr[w0+1]), 32'h000);
        check_val("wrap_d1",   wr_data[w0+1],      32'h08070605);

        // Throttled stream with a stray start mid-load
        stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        w0 = wr_cnt;
        do_start(10'h040, 12'd8);
        check_val("thr_wrap_cleared", 32'(wrap_err), 32'd0);
        send_stream(8, 1'b1, 1'b1);
        wait_done();
        check_val("thr_checksum", 32'(checksum), 32'h0264);
        tick();
        check_val("thr_nwr",  32'(wr_cnt - w0), 32'd2);
        check_val("thr_a0",   32'(wr_addr[w0]),   32'h040);
        check_val("thr_a1",   32'(wr_addr[w0+1]), 32'h041);
        check_val("thr_ram0", ram[10'h040], 32'h44332211);
        check_val("thr_ram1", ram[10'h041], 32'h88776655);
        check_val("thr_idle", 32'(busy), 32'd0);

        // Reset after two of four bytes
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        w0 = wr_cnt;
        do_start(10'h030, 12'd4);
        send_stream(2, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check_val("mrst_busy",     32'(busy), 32'd0);
        check_val("mrst_in_ready", 32'(bus.in_ready), 32'd0);
        check_val("mrst_addr",     32'(bus.mem_address), 32'd0);
        check_val("mrst_checksum", 32'(checksum), 32'd0);
        check_val("mrst_clken",    32'(bus.mem_clken), 32'd1);
        tick(); tick();
        reset = 1'b0;
        tick();
        check_val("mrst_nwr", 32'(wr_cnt - w0), 32'd0);
        check_val("mrst_ram", ram[10'h030], 32'h0);
        do_start(10'h030, 12'd4);
        send_stream(4, 1'b0, 1'b0);
        wait_done();
        check_val("post_checksum", 32'(checksum), 32'h000A);
        tick();
        check_val("post_nwr", 32'(wr_cnt - w0), 32'd1);
        check_val("post_ram", ram[10'h030], 32'h04030201);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
